// File: rtl/xosera_pkg.sv
// Shared Xosera types and board-level defaults.
// Board tops take the boot sequencer timing defaults from here.
package xv;

  typedef enum logic [2:0] {HOLD, QUALIFY, RUN, DRAIN, BOOT} boot_state_t;

  localparam int LOCK_STABLE_CYCLES    = 1024;
  localparam int RECONFIG_DRAIN_CYCLES = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for an asynchronous level input.
// Both flops clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/xosera_boot_ctrl.sv
// Reset and warm-boot sequencer: qualifies PLL lock before releasing the core,
// and turns a one-cycle reconfigure request into a drained SB_WARMBOOT sequence.
module xosera_boot_ctrl #(
  parameter int LOCK_STABLE_CYCLES    = xv::LOCK_STABLE_CYCLES,
  parameter int RECONFIG_DRAIN_CYCLES = xv::RECONFIG_DRAIN_CYCLES
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       pll_lock_i,
  input  logic       reconfig_i,
  input  logic [1:0] boot_select_i,
  output logic       main_reset_o,
  output logic       ready_o,
  output logic       boot_o,
  output logic [1:0] boot_s_o
);

  import xv::*;

  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, RECONFIG_DRAIN_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RECONFIG_DRAIN_CYCLES - 1);

  logic             lock_s;
  boot_state_t      state;
  boot_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       boot_s_next;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (reset_i),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state        <= HOLD;
      cnt          <= '0;
      main_reset_o <= 1'b1;
      ready_o      <= 1'b0;
      boot_o       <= 1'b0;
      boot_s_o     <= 2'b00;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      // outputs decode the next state so they change on the same edge as the state
      main_reset_o <= (state_next != RUN);
      ready_o      <= (state_next == RUN);
      boot_o       <= (state_next == BOOT);
      boot_s_o     <= boot_s_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    boot_s_next = boot_s_o;
    unique case (state)
      HOLD: begin
        cnt_next   = '0;
        state_next = QUALIFY;
      end
      QUALIFY: begin
        if (!lock_s) begin
          cnt_next = '0;
        end else if (cnt == LOCK_LAST) begin
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        // lock loss wins over a simultaneous reconfigure request
        if (!lock_s) begin
          state_next = HOLD;
        end else if (reconfig_i) begin
          boot_s_next = boot_select_i;
          state_next  = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = BOOT;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      BOOT: begin
        state_next = BOOT;
      end
      default: begin
        cnt_next   = '0;
        state_next = HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_xosera_boot_ctrl.sv
// Scoreboard bench for xosera_boot_ctrl with LOCK_STABLE_CYCLES=8, RECONFIG_DRAIN_CYCLES=4.
// Stimulus queues hand-computed outputs per cycle; a negedge monitor pops and compares.
module tb_xosera_boot_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       pll_lock_i;
  logic       reconfig_i;
  logic [1:0] boot_select_i;
  logic       main_reset_o;
  logic       ready_o;
  logic       boot_o;
  logic [1:0] boot_s_o;

  xosera_boot_ctrl #(
    .LOCK_STABLE_CYCLES    (8),
    .RECONFIG_DRAIN_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .pll_lock_i    (pll_lock_i),
    .reconfig_i    (reconfig_i),
    .boot_select_i (boot_select_i),
    .main_reset_o  (main_reset_o),
    .ready_o       (ready_o),
    .boot_o        (boot_o),
    .boot_s_o      (boot_s_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] exp;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected packing: {main_reset, ready, boot, boot_s[1:0]}
  task automatic expect_now(input logic mr, input logic rdy, input logic bt,
                            input logic [1:0] bs, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.exp = {mr, rdy, bt, bs};
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input logic mr, input logic rdy, input logic bt,
                      input logic [1:0] bs, input string nm);
    @(posedge clk);
    #1;
    expect_now(mr, rdy, bt, bs, nm);
  endtask

  // reset asserted mid-cycle: outputs must be at reset values before the next edge
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    expect_now(1'b1, 1'b0, 1'b0, 2'b00, "rst_async");
    @(posedge clk);
    #1;
    expect_now(1'b1, 1'b0, 1'b0, 2'b00, "rst_hold");
    reset_i = 1'b0;
  endtask

  task automatic power_up(input string nm);
    for (int i = 1; i <= 9; i++) tick(1'b1, 1'b0, 1'b0, 2'b00, {nm, "_hold"});
    tick(1'b0, 1'b1, 1'b0, 2'b00, {nm, "_run"});
  endtask

  exp_t       mon_e;
  logic [4:0] mon_act;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = {main_reset_o, ready_o, boot_o, boot_s_o};
      n_cmp++;
      if (mon_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", mon_e.nm, mon_e.cyc, cyc);
      end else if (mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got mr/rdy/boot/bs=%b, want %b", mon_e.nm, cyc, mon_act, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i       = 1'b1;
    pll_lock_i    = 1'b1;
    reconfig_i    = 1'b0;
    boot_select_i = 2'b00;

    // power-up with lock steady
    do_reset();
    power_up("pwr");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "pwr_run2");

    // one-cycle lock glitch mid-qualify
    do_reset();
    for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0, 1'b0, 2'b00, "glitch_pre");
    pll_lock_i = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 2'b00, "glitch_low");
    pll_lock_i = 1'b1;
    for (int i = 7; i <= 15; i++) tick(1'b1, 1'b0, 1'b0, 2'b00, "glitch_requal");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "glitch_run");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "glitch_run2");

    // lock drop in RUN
    pll_lock_i = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 2'b00, "drop_d1");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "drop_d2");
    tick(1'b1, 1'b0, 1'b0, 2'b00, "drop_d3");
    tick(1'b1, 1'b0, 1'b0, 2'b00, "drop_d4");
    tick(1'b1, 1'b0, 1'b0, 2'b00, "drop_d5");
    pll_lock_i = 1'b1;
    power_up("relock");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "relock_run2");

    // reconfigure; later select changes, repeat request and lock loss are ignored
    reconfig_i    = 1'b1;
    boot_select_i = 2'b10;
    tick(1'b1, 1'b0, 1'b0, 2'b10, "rcfg_k");
    reconfig_i    = 1'b0;
    boot_select_i = 2'b01;
    tick(1'b1, 1'b0, 1'b0, 2'b10, "rcfg_k1");
    pll_lock_i = 1'b0;
    reconfig_i = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 2'b10, "rcfg_k2");
    reconfig_i = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 2'b10, "rcfg_k3");
    tick(1'b1, 1'b0, 1'b1, 2'b10, "boot_k4");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 2'b10, "boot_stay");

    // reset while in BOOT, then normal power-up
    pll_lock_i    = 1'b1;
    boot_select_i = 2'b00;
    do_reset();
    power_up("pwr2");

    // reconfigure and lock loss sampled on the same edge
    pll_lock_i = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 2'b00, "same_d1");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "same_d2");
    reconfig_i    = 1'b1;
    boot_select_i = 2'b11;
    tick(1'b1, 1'b0, 1'b0, 2'b00, "same_hold");
    reconfig_i = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 2'b00, "same_after1");
    tick(1'b1, 1'b0, 1'b0, 2'b00, "same_after2");
    // request outside RUN must not be remembered
    reconfig_i = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 2'b00, "noq_qual");
    reconfig_i = 1'b0;
    pll_lock_i = 1'b1;
    power_up("noq");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "noq_run2");
    tick(1'b0, 1'b1, 1'b0, 2'b00, "noq_run3");

    // reset while in DRAIN
    reconfig_i    = 1'b1;
    boot_select_i = 2'b01;
    tick(1'b1, 1'b0, 1'b0, 2'b01, "drain_k");
    reconfig_i = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 2'b01, "drain_k1");
    do_reset();
    power_up("pwr3");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain_queue: got %0d unchecked expectations, want 0", sb.size());
      n_cmp  += sb.size();
      n_fail += sb.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
